// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the byte-serial memory port: controller states, access
// length codes and port ownership.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // Number of byte transfers for a length code; 11 is treated as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates a single byte-wide RAM port between instruction fetch and the MEM
// stage, serialising 8/16/32-bit accesses into little-endian byte transfers.
module mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              jump_i,
    output logic [31:0]       if_inst_o,
    output logic              if_done_o,
    output logic              if_busy_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              mem_busy_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    state_t            state;
    owner_t            owner;
    logic              we;
    logic [2:0]        k;
    logic [2:0]        n;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       wdata;
    logic [31:0]       asm_buf;
    logic [31:0]       asm_next;

    logic              accept;
    logic              new_we;
    logic [ADDR_W-1:0] new_addr;
    logic [2:0]        k_p1;
    logic [1:0]        cap_idx;
    logic              unused_addr_hi;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[8*idx +: 8];
    endfunction

    // MEM has priority; only the low ADDR_W address bits reach the RAM.
    assign accept   = (state == IDLE) && (if_req_i || mem_req_i);
    assign new_we   = mem_req_i & mem_we_i;
    assign new_addr = mem_req_i ? mem_addr_i[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
    assign k_p1     = k + 3'd1;

    // RAM data arriving now belongs to the address issued one cycle earlier.
    assign cap_idx  = k[1:0] - 2'd1;

    always_comb begin
        asm_next = asm_buf;
        asm_next[8*cap_idx +: 8] = ram_din_i;
    end

    assign mem_busy_o     = mem_req_i & ~mem_done_o;
    assign unused_addr_hi = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            we          <= 1'b0;
            k           <= 3'd0;
            n           <= 3'd0;
            ram_addr_o  <= '0;
            ram_dout_o  <= 8'h00;
            ram_wr_o    <= 1'b0;
            if_inst_o   <= 32'h0;
            if_done_o   <= 1'b0;
            if_busy_o   <= 1'b1;
            mem_rdata_o <= 32'h0;
            mem_done_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= XFER;
                        owner      <= mem_req_i ? OWN_MEM : OWN_IF;
                        we         <= new_we;
                        n          <= mem_req_i ? len_bytes(mem_len_i) : 3'd4;
                        k          <= 3'd0;
                        ram_addr_o <= new_addr;
                        ram_wr_o   <= new_we;
                        if (new_we) begin
                            ram_dout_o <= mem_wdata_i[7:0];
                        end
                    end
                end
                XFER: begin
                    if (owner == OWN_IF && jump_i) begin
                        state    <= IDLE;
                        ram_wr_o <= 1'b0;
                    end else if (we) begin
                        if (k_p1 < n) begin
                            ram_addr_o <= base_addr + ADDR_W'(k_p1);
                            ram_dout_o <= byte_sel(wdata, k_p1[1:0]);
                            ram_wr_o   <= 1'b1;
                            k          <= k_p1;
                        end else begin
                            ram_wr_o   <= 1'b0;
                            state      <= DONE;
                            mem_done_o <= 1'b1;
                        end
                    end else begin
                        // Reads run one cycle past the last address to collect its byte.
                        if (k_p1 < n) begin
                            ram_addr_o <= base_addr + ADDR_W'(k_p1);
                        end
                        if (k == n) begin
                            state <= DONE;
                            if (owner == OWN_MEM) begin
                                mem_done_o  <= 1'b1;
                                mem_rdata_o <= asm_next;
                            end else begin
                                if_done_o <= 1'b1;
                                if_busy_o <= 1'b0;
                                if_inst_o <= asm_next;
                            end
                        end
                        k <= k_p1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    if_done_o  <= 1'b0;
                    mem_done_o <= 1'b0;
                    if_busy_o  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath registers: loaded on acceptance, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_addr <= new_addr;
            wdata     <= mem_wdata_i;
            asm_buf   <= 32'h0;
        end else if (state == XFER && k != 3'd0) begin
            asm_buf <= asm_next;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, shadow memory reference, directed vectors,
// multi-cycle corner sequences and randomized accesses.
module tb_mem_ctrl;

    localparam int AW = 17;
    localparam int RAM_SIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i;
    logic [31:0]   if_addr_i;
    logic          jump_i;
    logic [31:0]   if_inst_o;
    logic          if_done_o;
    logic          if_busy_o;
    logic          mem_req_i;
    logic          mem_we_i;
    logic [1:0]    mem_len_i;
    logic [31:0]   mem_addr_i;
    logic [31:0]   mem_wdata_i;
    logic [31:0]   mem_rdata_o;
    logic          mem_done_o;
    logic          mem_busy_o;
    logic [AW-1:0] ram_addr_o;
    logic [7:0]    ram_dout_o;
    logic          ram_wr_o;
    logic [7:0]    ram_din_i;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .jump_i(jump_i),
        .if_inst_o(if_inst_o), .if_done_o(if_done_o), .if_busy_o(if_busy_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .mem_busy_o(mem_busy_o),
        .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
        .ram_din_i(ram_din_i)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM with one-cycle read latency, plus preload/poke hooks.
    logic [7:0]    ram     [0:RAM_SIZE-1];
    logic [7:0]    ref_mem [0:RAM_SIZE-1];
    logic          ram_init;
    logic          poke_en;
    logic [AW-1:0] poke_addr;
    logic [7:0]    poke_val;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 73 + 5) ^ (i >> 8));
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < RAM_SIZE; i++) ram[i] <= init_byte(i);
        end else if (poke_en) begin
            ram[poke_addr] <= poke_val;
        end else if (ram_wr_o) begin
            ram[ram_addr_o] <= ram_dout_o;
        end
        ram_din_i <= ram[ram_addr_o];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int len_n(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = ref_mem[AW'(addr + 32'(i))];
        return w;
    endfunction

    task automatic poke(input logic [31:0] addr, input logic [7:0] v);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = AW'(addr);
        poke_val  = v;
        ref_mem[AW'(addr)] = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // One transaction from an idle controller: checks the RAM-side byte sequence
    // and busy flags, returns the done cycle (0 = never) and the returned word.
    task automatic txn(input bit is_mem, input bit we, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wd, input string nm,
                       output logic [31:0] data, output int done_cyc);
        int n, lat;
        bit addr_ok, wr_ok, busy_ok;
        logic [AW-1:0] ea;
        n   = is_mem ? len_n(len) : 4;
        lat = (is_mem && we) ? n + 1 : n + 2;
        addr_ok = 1'b1; wr_ok = 1'b1; busy_ok = 1'b1;
        done_cyc = 0; data = 32'h0;
        @(negedge clk);
        if (is_mem) begin
            mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len;
            mem_addr_i = addr; mem_wdata_i = wd;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        @(posedge clk);
        for (int c = 1; c <= lat + 2; c++) begin
            @(negedge clk);
            ea = AW'(addr + 32'(c - 1));
            if (c <= n) begin
                if (ram_addr_o !== ea) addr_ok = 1'b0;
                if (ram_wr_o !== (is_mem && we)) wr_ok = 1'b0;
                if (is_mem && we && ram_dout_o !== wd[8*(c-1) +: 8]) wr_ok = 1'b0;
            end else if (ram_wr_o !== 1'b0) begin
                wr_ok = 1'b0;
            end
            if (is_mem ? (mem_busy_o !== !mem_done_o) : (if_busy_o !== !if_done_o)) busy_ok = 1'b0;
            if (is_mem ? mem_done_o : if_done_o) begin
                done_cyc = c;
                data = is_mem ? mem_rdata_o : if_inst_o;
                break;
            end
        end
        mem_req_i = 1'b0;
        if_req_i  = 1'b0;
        if (is_mem && we)
            for (int i = 0; i < n; i++) ref_mem[AW'(addr + 32'(i))] = wd[8*i +: 8];
        check({nm, "_addr"}, 32'(addr_ok), 32'd1);
        check({nm, "_wr"},   32'(wr_ok),   32'd1);
        check({nm, "_busy"}, 32'(busy_ok), 32'd1);
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    initial begin : main
        vec_t        vecs [11];
        logic [31:0] data, exp, last_if, a;
        int          dc, mem_at, if_at, n;
        bit          busy_ok, seen, is_mem, we;
        logic [1:0]  len;

        rst = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0; jump_i = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = 2'b00;
        mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
        poke_en = 1'b0; poke_addr = '0; poke_val = 8'h00; ram_init = 1'b1;
        for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = init_byte(i);
        @(negedge clk);
        ram_init = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_if_busy",   32'(if_busy_o),  32'd1);
        check("rst_if_done",   32'(if_done_o),  32'd0);
        check("rst_if_inst",   if_inst_o,       32'h0);
        check("rst_mem_done",  32'(mem_done_o), 32'd0);
        check("rst_mem_busy",  32'(mem_busy_o), 32'd0);
        check("rst_mem_rdata", mem_rdata_o,     32'h0);
        check("rst_ram_addr",  32'(ram_addr_o), 32'h0);
        check("rst_ram_dout",  32'(ram_dout_o), 32'h0);
        check("rst_ram_wr",    32'(ram_wr_o),   32'd0);

        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
        poke(32'h3, 8'h80);
        poke(32'h1FFFE, 8'h11); poke(32'h1FFFF, 8'h22); poke(32'h0, 8'h33); poke(32'h1, 8'h44);

        vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h00000100, 32'h0,        6, 32'h00100513};
        vecs[1]  = '{1'b1, 1'b1, 2'b10, 32'h00000200, 32'hDEADBEEF, 5, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 32'h00000200, 32'h0,        6, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 2'b00, 32'h00000003, 32'h0,        3, 32'h00000080};
        vecs[4]  = '{1'b1, 1'b0, 2'b11, 32'h0001FFFE, 32'h0,        6, 32'h44332211};
        vecs[5]  = '{1'b1, 1'b1, 2'b01, 32'h0001FFFF, 32'hABCD1234, 3, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 32'h0001FFFF, 32'h0,        4, 32'h00001234};
        vecs[7]  = '{1'b1, 1'b0, 2'b00, 32'h00000000, 32'h0,        3, 32'h00000012};
        vecs[8]  = '{1'b1, 1'b1, 2'b00, 32'hFFFE0010, 32'h0000005A, 2, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 32'h00000010, 32'h0,        3, 32'h0000005A};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 32'h0001FFFE, 32'h0,        6, 32'h44123411};

        for (int i = 0; i < 11; i++) begin
            txn(vecs[i].is_mem, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata,
                $sformatf("vec%0d", i), data, dc);
            check($sformatf("vec%0d_lat", i), 32'(dc), 32'(vecs[i].lat));
            if (!vecs[i].we) check($sformatf("vec%0d_data", i), data, vecs[i].exp);
        end

        // Simultaneous requests: MEM word write first, IF fetch in the following IDLE.
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
        mem_addr_i = 32'h200; mem_wdata_i = 32'hCAFEF00D;
        if_req_i = 1'b1; if_addr_i = 32'h100;
        for (int i = 0; i < 4; i++) ref_mem[AW'(32'h200 + 32'(i))] = 8'(32'hCAFEF00D >> (8*i));
        exp = ref_read(32'h100, 4);
        @(posedge clk);
        busy_ok = 1'b1; mem_at = 0; if_at = 0; data = 32'h0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (if_busy_o !== !if_done_o) busy_ok = 1'b0;
            if (mem_done_o && mem_at == 0) begin
                mem_at = c;
                mem_req_i = 1'b0;
            end
            if (if_done_o) begin
                if_at = c;
                data = if_inst_o;
                break;
            end
        end
        if_req_i = 1'b0; mem_req_i = 1'b0;
        check("both_mem_done_cyc", 32'(mem_at), 32'd5);
        check("both_if_done_cyc",  32'(if_at),  32'd12);
        check("both_if_inst",      data,        exp);
        check("both_if_busy",      32'(busy_ok), 32'd1);
        check("both_ram_bytes", {ram[AW'(32'h203)], ram[AW'(32'h202)], ram[AW'(32'h201)], ram[AW'(32'h200)]},
              32'hCAFEF00D);

        // Jump in cycle 2 of a fetch: abort, then refetch from the new address.
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h100;
        exp = ref_read(32'h200, 4);
        @(posedge clk);
        seen = 1'b0; if_at = 0; data = 32'h0;
        @(negedge clk);
        seen |= if_done_o;
        @(negedge clk);
        seen |= if_done_o;
        jump_i = 1'b1; if_addr_i = 32'h200;
        @(negedge clk);
        seen |= if_done_o;
        jump_i = 1'b0;
        for (int c = 4; c <= 14; c++) begin
            @(negedge clk);
            if (c == 4) check("jump_new_addr", 32'(ram_addr_o), 32'h200);
            if (if_done_o) begin
                if_at = c;
                data = if_inst_o;
                break;
            end
        end
        if_req_i = 1'b0;
        check("jump_no_done",  32'(seen),  32'd0);
        check("jump_done_cyc", 32'(if_at), 32'd9);
        check("jump_inst",     data,       exp);

        // Reset during cycle 2 of a word write.
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
        mem_addr_i = 32'h300; mem_wdata_i = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; mem_req_i = 1'b0;
        ref_mem[AW'(32'h300)] = 8'h44;
        ref_mem[AW'(32'h301)] = 8'h33;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_ram_wr",    32'(ram_wr_o),   32'd0);
        check("mrst_if_busy",   32'(if_busy_o),  32'd1);
        check("mrst_mem_done",  32'(mem_done_o), 32'd0);
        check("mrst_mem_busy",  32'(mem_busy_o), 32'd0);
        check("mrst_ram_addr",  32'(ram_addr_o), 32'h0);
        check("mrst_ram_dout",  32'(ram_dout_o), 32'h0);
        check("mrst_if_inst",   if_inst_o,       32'h0);
        check("mrst_mem_rdata", mem_rdata_o,     32'h0);
        check("mrst_byte0",     32'(ram[AW'(32'h300)]), 32'h44);

        // Randomized accesses against the shadow memory.
        last_if = 32'h0;
        for (int t = 0; t < 80; t++) begin
            is_mem = 1'($urandom_range(0, 1));
            we     = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
            len    = 2'($urandom_range(0, 3));
            a      = $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31:AW], 17'h1FFFC + 17'($urandom_range(0, 3))};
            n      = is_mem ? len_n(len) : 4;
            exp    = ref_read(a, n);
            check($sformatf("rnd%0d_if_hold", t), if_inst_o, last_if);
            txn(is_mem, we, len, a, $urandom, $sformatf("rnd%0d", t), data, dc);
            check($sformatf("rnd%0d_lat", t), 32'(dc), 32'((is_mem && we) ? n + 1 : n + 2));
            if (!we) check($sformatf("rnd%0d_data", t), data, exp);
            if (!is_mem) last_if = exp;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
